rr_arbiter_8: RTL

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

---
 rtl/rr_arbiter_8_pkg.sv | 23 ++
 rtl/rr_arbiter_8_pick.sv | 25 ++
 rtl/rr_arbiter_8.sv | 97 +++++++++
 3 files changed

// File: rtl/rr_arbiter_8_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// Also provides a one-hot to index helper used to locate the current owner.
package rr_arbiter_8_pkg;

    localparam int unsigned N_REQ  = 8;
    localparam int unsigned PTR_W  = 3;
    localparam int unsigned HOLD_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = PTR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_8_pick.sv
// Rotating-priority pick: one-hot of the first set req bit at or after ptr,
// found by rotating req down by ptr, isolating the lowest set bit, rotating back.
module rr_pick8
    import rr_arbiter_8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] pick
);

    logic [2*N_REQ-1:0] dbl_req;
    logic [2*N_REQ-1:0] dbl_pick;
    logic [N_REQ-1:0]   rot_req;
    logic [N_REQ-1:0]   rot_pick;

    // NOTE: every variable gets a value on every path through always_comb; otherwise a latch is inferred.
    always_comb begin
        dbl_req  = {req, req} >> ptr;
        rot_req  = dbl_req[N_REQ-1:0];
        rot_pick = rot_req & (~rot_req + N_REQ'(1));
        dbl_pick = {rot_pick, rot_pick} << ptr;
        pick     = dbl_pick[2*N_REQ-1:N_REQ];
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with a bounded hold time and a mandatory idle cycle
// between owners; grant and valid are registered.
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic             valid
);

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q,   ptr_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [HOLD_W-1:0]  hold_q,  hold_d;
    logic               valid_q, valid_d;

    logic [N_REQ-1:0]   pick;
    logic [PTR_W-1:0]   owner_idx;
    logic               owner_req;
    logic               release_now;

    rr_pick8 u_pick (
        .req  (req),
        .ptr  (ptr_q),
        .pick (pick)
    );

    assign owner_idx   = onehot_to_idx(grant_q);
    assign owner_req   = req[owner_idx];
    assign release_now = done || !owner_req || (hold_q >= MAX_HOLD_C);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        hold_d  = hold_q;

        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                hold_d  = '0;
                if (en && (|req)) begin
                    state_d = BUSY;
                    grant_d = pick;
                    hold_d  = HOLD_W'(1);
                end
            end
            BUSY: begin
                // Withdrawal by en has priority over done and leaves ptr alone.
                if (!en) begin
                    state_d = IDLE;
                    grant_d = '0;
                    hold_d  = '0;
                end else if (release_now) begin
                    state_d = IDLE;
                    grant_d = '0;
                    hold_d  = '0;
                    ptr_d   = owner_idx + PTR_W'(1);
                end else begin
                    hold_d  = hold_q + HOLD_W'(1);
                end
            end
        endcase

        valid_d = |grant_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: all state here is a handful of flops, so every one of them is reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end

    assign grant = grant_q;
    assign valid = valid_q;

endmodule
